// File: rtl/srcdenc.sv
// Prefetch-word decoder: classifies each opcode into a source-data type code and
// assembles the 32-bit MOVEI immediate from the two words that follow it.
module srcdenc (
   input  logic        clk,
   input  logic        resetl,
   input  logic [15:0] iw,
   input  logic        iw_valid,
   output logic        iw_ready,
   input  logic        flush,
   input  logic        op_ready,
   output logic        op_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  srcop,
   output logic [4:0]  dstop,
   output logic        srcdat_0,
   output logic        srcdat_1,
   output logic        srcdat_2,
   output logic        srcdat_3,
   output logic [31:0] imm,
   output logic        imm_valid
);

   typedef enum logic [1:0] {DEC, IMLO, IMHI, HOLD} state_e;

   localparam logic [5:0] OP_MOVEI = 6'd38;

   state_e      state_q;
   logic        op_valid_q;
   logic        imm_valid_q;
   logic [5:0]  opcode_q;
   logic [4:0]  srcop_q;
   logic [4:0]  dstop_q;
   logic [3:0]  srcdat_q;
   logic [3:0]  srcdat_d;
   logic [31:0] imm_q;
   logic        accept;

   // srcdat_d[3] is s0, so the literals read left to right as s0..s3
   always_comb begin
      srcdat_d = '0;
      case (iw[15:10])
         6'd2, 6'd6, 6'd24, 6'd25: srcdat_d = 4'b1000;
         6'd31, 6'd53:             srcdat_d = 4'b1010;
         6'd14:                    srcdat_d = 4'b0101;
         6'd15:                    srcdat_d = 4'b1001;
         6'd51:                    srcdat_d = 4'b1110;
         default:                  srcdat_d = 4'b0000;
      endcase
   end

   always_comb begin
      iw_ready = 1'b0;
      if (resetl && !flush) begin
         unique case (state_q)
            DEC:        iw_ready = ~op_valid_q | op_ready;
            IMLO, IMHI: iw_ready = 1'b1;
            HOLD:       iw_ready = 1'b0;
         endcase
      end
   end

   assign accept = iw_valid & iw_ready;

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state_q     <= DEC;
         op_valid_q  <= 1'b0;
         imm_valid_q <= 1'b0;
         opcode_q    <= '0;
         srcop_q     <= '0;
         dstop_q     <= '0;
         srcdat_q    <= '0;
         imm_q       <= '0;
      end else if (flush) begin
         state_q     <= DEC;
         op_valid_q  <= 1'b0;
         imm_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            DEC: begin
               if (accept) begin
                  opcode_q <= iw[15:10];
                  srcop_q  <= iw[9:5];
                  dstop_q  <= iw[4:0];
                  srcdat_q <= srcdat_d;
                  if (iw[15:10] == OP_MOVEI) begin
                     state_q    <= IMLO;
                     op_valid_q <= 1'b0;
                  end else begin
                     op_valid_q <= 1'b1;
                  end
               end else if (op_ready) begin
                  op_valid_q <= 1'b0;
               end
            end
            IMLO: begin
               if (accept) begin
                  imm_q[15:0] <= iw;
                  state_q     <= IMHI;
               end
            end
            IMHI: begin
               if (accept) begin
                  imm_q[31:16] <= iw;
                  imm_valid_q  <= 1'b1;
                  op_valid_q   <= 1'b1;
                  state_q      <= HOLD;
               end
            end
            HOLD: begin
               if (op_ready) begin
                  state_q     <= DEC;
                  op_valid_q  <= 1'b0;
                  imm_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign op_valid  = op_valid_q;
   assign imm_valid = imm_valid_q;
   assign opcode    = opcode_q;
   assign srcop     = srcop_q;
   assign dstop     = dstop_q;
   assign srcdat_0  = srcdat_q[3];
   assign srcdat_1  = srcdat_q[2];
   assign srcdat_2  = srcdat_q[1];
   assign srcdat_3  = srcdat_q[0];
   assign imm       = imm_q;

endmodule
